// File: rtl/pvt_seu_pkg.sv
// Shared definitions for the triple-redundant scrubbed register file.
// Holds the scrubber FSM state type, the error-counter width and the
// default values of the block parameters.
package pvt_seu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scrub_state_t;

    localparam int ERR_W              = 16;
    localparam int DEF_DEPTH          = 8;
    localparam int DEF_WIDTH          = 8;
    localparam int DEF_SCRUB_INTERVAL = 256;

endpackage

// File: rtl/tmr_scrub_regfile_if.sv
// Bus bundle for tmr_scrub_regfile.
// Ports carried: user write (wr_en/wr_addr/wr_data), voted read
// (rd_addr/rd_data), fault injection (inj_en/inj_addr/inj_copy/inj_mask),
// scrub control (scrub_en, clr_count) and scrub status
// (scrub_busy, err_pulse, err_addr, err_count).
// master drives the requests, slave is the register file.
interface tmr_scrub_regfile_if import pvt_seu_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             inj_en;
    logic [AW-1:0]    inj_addr;
    logic [1:0]       inj_copy;
    logic [WIDTH-1:0] inj_mask;
    logic             scrub_en;
    logic             clr_count;
    logic             scrub_busy;
    logic             err_pulse;
    logic [AW-1:0]    err_addr;
    logic [ERR_W-1:0] err_count;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        output inj_en, inj_addr, inj_copy, inj_mask,
        output scrub_en, clr_count,
        input  rd_data, scrub_busy, err_pulse, err_addr, err_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  inj_en, inj_addr, inj_copy, inj_mask,
        input  scrub_en, clr_count,
        output rd_data, scrub_busy, err_pulse, err_addr, err_count
    );

endinterface

// File: rtl/tmr_vote.sv
// Combinational triple-modular-redundancy voter.
// Ports: a, b, c - the three stored copies of one word;
//        vote     - per-bit two-of-three majority;
//        mismatch - high when any copy disagrees with the vote.
module tmr_vote #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] vote,
    output logic             mismatch
);

    assign vote     = (a & b) | (a & c) | (b & c);
    assign mismatch = (a != vote) || (b != vote) || (c != vote);

endmodule

// File: rtl/tmr_scrub_regfile.sv
// Triple-redundant register file with periodic background scrubbing.
// Ports: clk, rst (synchronous, active-high) and a slave bus carrying
// write, voted read (1-cycle latency), fault injection into one copy,
// scrub enable, error-count clear, and scrub status outputs
// (scrub_busy, err_pulse/err_addr for each corrected word, err_count).
module tmr_scrub_regfile import pvt_seu_pkg::*; #(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SCRUB_INTERVAL = DEF_SCRUB_INTERVAL
) (
    input  logic              clk,
    input  logic              rst,
    tmr_scrub_regfile_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SCRUB_INTERVAL);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCRUB_INTERVAL - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [WIDTH-1:0] mem_c [DEPTH];

    scrub_state_t     state;
    logic [CW-1:0]    ivl_cnt;
    logic [AW-1:0]    scan_addr;
    logic [WIDTH-1:0] rd_data_p1;
    logic             err_pulse_p1;
    logic [AW-1:0]    err_addr_p1;
    logic [ERR_W-1:0] err_count_q;

    logic [WIDTH-1:0] rd_vote;
    logic             rd_mismatch_unused;
    logic [WIDTH-1:0] scan_vote;
    logic             scan_mismatch;
    logic             wr_hits_scan;
    logic             corr_fire;

    tmr_vote #(.WIDTH(WIDTH)) u_rd_vote (
        .a        (mem_a[bus.rd_addr]),
        .b        (mem_b[bus.rd_addr]),
        .c        (mem_c[bus.rd_addr]),
        .vote     (rd_vote),
        .mismatch (rd_mismatch_unused)
    );

    tmr_vote #(.WIDTH(WIDTH)) u_scan_vote (
        .a        (mem_a[scan_addr]),
        .b        (mem_b[scan_addr]),
        .c        (mem_c[scan_addr]),
        .vote     (scan_vote),
        .mismatch (scan_mismatch)
    );

    // A user write to the word being scanned supersedes the correction, so
    // the correction is neither applied nor reported.
    assign wr_hits_scan = bus.wr_en && (bus.wr_addr == scan_addr);
    assign corr_fire    = (state == ST_SCAN) && scan_mismatch && !wr_hits_scan;

    // Storage update. The three sources are applied lowest priority first:
    // on a shared address the later non-blocking assignment wins, which drops
    // the injection under a correction or write and the correction under a
    // write, while actions on distinct addresses all land.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
                mem_c[i] <= '0;
            end
        end else begin
            if (bus.inj_en) begin
                case (bus.inj_copy)
                    2'd0:    mem_a[bus.inj_addr] <= mem_a[bus.inj_addr] ^ bus.inj_mask;
                    2'd1:    mem_b[bus.inj_addr] <= mem_b[bus.inj_addr] ^ bus.inj_mask;
                    2'd2:    mem_c[bus.inj_addr] <= mem_c[bus.inj_addr] ^ bus.inj_mask;
                    default: ;
                endcase
            end
            if (corr_fire) begin
                mem_a[scan_addr] <= scan_vote;
                mem_b[scan_addr] <= scan_vote;
                mem_c[scan_addr] <= scan_vote;
            end
            if (bus.wr_en) begin
                mem_a[bus.wr_addr] <= bus.wr_data;
                mem_b[bus.wr_addr] <= bus.wr_data;
                mem_c[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // Stage p1: registered read data, scrub FSM and error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ivl_cnt      <= '0;
            scan_addr    <= '0;
            rd_data_p1   <= '0;
            err_pulse_p1 <= 1'b0;
            err_addr_p1  <= '0;
            err_count_q  <= '0;
        end else begin
            rd_data_p1   <= rd_vote;
            err_pulse_p1 <= corr_fire;
            if (corr_fire) begin
                err_addr_p1 <= scan_addr;
            end
            if (bus.clr_count) begin
                err_count_q <= '0;
            end else if (corr_fire) begin
                err_count_q <= sat_inc(err_count_q);
            end

            case (state)
                ST_IDLE: begin
                    if (!bus.scrub_en) begin
                        ivl_cnt <= '0;
                    end else if (ivl_cnt == CNT_LAST) begin
                        state     <= ST_SCAN;
                        ivl_cnt   <= '0;
                        scan_addr <= '0;
                    end else begin
                        ivl_cnt <= ivl_cnt + CW'(1);
                    end
                end
                ST_SCAN: begin
                    // scrub_en is ignored here so a started pass always completes.
                    if (scan_addr == ADDR_LAST) begin
                        state     <= ST_IDLE;
                        scan_addr <= '0;
                    end else begin
                        scan_addr <= scan_addr + AW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_data    = rd_data_p1;
    assign bus.scrub_busy = (state == ST_SCAN);
    assign bus.err_pulse  = err_pulse_p1;
    assign bus.err_addr   = err_addr_p1;
    assign bus.err_count  = err_count_q;

endmodule

// File: doc/tmr_scrub_regfile.md
TMR_SCRUB_REGFILE -- requirements
Module: tmr_scrub_regfile

Interface
REQ-001 Parameter DEPTH, default 8: number of stored words (power of two, >=2).
REQ-002 Parameter WIDTH, default 8: bits per word.
REQ-003 Parameter SCRUB_INTERVAL, default 256: idle cycles between scrub passes (>=2).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_en / wr_addr / wr_data  input  1 / AW=$clog2(DEPTH) / WIDTH  user write of all three copies.
REQ-007 rd_addr  input  AW;  rd_data  output  WIDTH  registered majority-voted read.
REQ-008 inj_en / inj_addr / inj_copy / inj_mask  input  1 / AW / 2 / WIDTH  fault injection: XOR mask into one copy.
REQ-009 scrub_en  input  1  enables periodic scrubbing.
REQ-010 clr_count  input  1  clears err_count.
REQ-011 scrub_busy  output  1  high while a pass is in progress.
REQ-012 err_pulse / err_addr  output  1 / AW  one-cycle flag and address of each corrected word.
REQ-013 err_count  output  16  saturating count of corrected words.

Function
REQ-014 Storage: three copies (A,B,C) of DEPTH x WIDTH; a word's value is the per-bit majority of A,B,C.
REQ-015 Write: wr_en stores wr_data into A,B,C at wr_addr on the next edge.
REQ-016 Read: rd_data = vote(rd_addr) sampled from pre-edge state, latency 1 cycle; same-cycle write is not visible until the following read.
REQ-017 Injection: inj_en XORs inj_mask into copy inj_copy (0=A,1=B,2=C) at inj_addr; inj_copy=3 ignored.
REQ-018 FSM states IDLE, SCAN. IDLE: interval counter increments while scrub_en=1, held at 0 while scrub_en=0; at SCRUB_INTERVAL-1 go to SCAN with scan_addr=0, counter to 0.
REQ-019 SCAN: one word per cycle at scan_addr; if any copy differs from the vote, write vote to all three copies, assert err_pulse with err_addr=scan_addr for that cycle, increment err_count.
REQ-020 SCAN: scan_addr increments each cycle; after scan_addr=DEPTH-1 return to IDLE; a pass is exactly DEPTH cycles.
REQ-021 scrub_busy=1 exactly in SCAN; deasserting scrub_en mid-pass does not abort the pass.
REQ-022 Same-address priority: write > scrub correction > injection; a lower-priority action on the same address in the same cycle is dropped, with no err_pulse or count for a dropped correction.
REQ-023 Different-address write, correction and injection in the same cycle all take effect.
REQ-024 err_count saturates at 16'hFFFF; clr_count takes priority over a same-cycle increment (result 0).
REQ-025 A word with two bad copies is voted and corrected to the two-copy majority per bit, without distinguishing it from a single-copy error.

Reset
REQ-026 rst=1 sets all copies to 0, FSM to IDLE, interval counter and scan_addr to 0, rd_data=0, err_pulse=0, err_addr=0, err_count=0, scrub_busy=0; rst mid-pass abandons the pass.
REQ-027 rst overrides every other input in the same cycle.

Structure
REQ-028 Package pvt_seu_pkg holds the FSM state enum, the err_count width constant (16) and the default parameter values.
REQ-029 Sub-module tmr_vote (combinational per-bit majority plus mismatch flag, WIDTH-parameterised) is instantiated once for the read port and once for the scan port.

Verification
REQ-030 Write 8'hA5 at addr 3, read addr 3 -> rd_data=8'hA5 one cycle after rd_addr is applied; err_count=0.
REQ-031 Write 8'h3C at addr 5, inject mask 8'hFF into copy B -> read still 8'h3C; the next pass gives one err_pulse with err_addr=5 and err_count=1; copy B=8'h3C afterwards.
REQ-032 Write 8'h00 at addr 2, inject 8'h0F into A and 8'h0F into B -> the pass corrects to 8'h0F on all copies, err_count+1.
REQ-033 Inject at addr 4 and write 8'h77 at addr 4 in the same cycle while scan_addr=4 -> stored 8'h77 in all copies, no err_pulse.
REQ-034 Force err_count to 16'hFFFF via repeated injection, then inject again -> stays 16'hFFFF; clr_count with a same-cycle error -> 0.
REQ-035 Assert rst on the 3rd cycle of SCAN -> next cycle scrub_busy=0, all outputs 0, and the next pass starts SCRUB_INTERVAL cycles after rst release with scrub_en=1.
